led_matrix_scan: RTL and testbench
==================================

// Module: led_matrix_scan
// PURPOSE
//  Row-multiplexed driver for the 8x8 LED matrix. Consumes 64-bit frames from the
//  counter/glyph stage and drives the STRING (row) and COLUMN (pixel) board pins.
//  Double-buffered: a new frame is applied only at a frame boundary, so no tearing.
//  A per-row blanking interval suppresses ghosting.
// PARAMETERS
//  CLK_REF        48_000_000  system clock frequency, Hz
//  ROW_RATE       8_000       row switch rate, Hz; ROW_DIV = CLK_REF/ROW_RATE (6000)
//  BLANK_CYC      48          blanked clocks at the start of each row dwell; must be < ROW_DIV
//  COL_ACTIVE_LOW 1           1: lit pixel drives COLUMN bit 0; 0: lit drives 1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  frame_i    in   64  frame; row r = frame_i[8*r+7:8*r], bit c = column c, 1 = lit
//  frame_vld  in   1   frame_i valid
//  frame_rdy  out  1   shadow buffer empty; transfer on frame_vld & frame_rdy
//  blank_i    in   1   force display dark; scan timing keeps running
//  STRING     out  8   one-hot row select, active-high
//  COLUMN     out  8   column drive, polarity set by COL_ACTIVE_LOW
//  frame_sync out  1   one-clock pulse when row 0 begins
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst is synchronous and active-high.
//  Reset values: STRING=0; COLUMN=all-off (8'hFF if COL_ACTIVE_LOW); frame_rdy=1;
//    frame_sync=0. Internal state on reset: div=0, row=0, active=0, shadow empty.
//    A reset in mid-scan or mid-frame discards any pending shadow frame.
//  Timing: div counts 0..ROW_DIV-1. At div==ROW_DIV-1, div wraps to 0 and row
//    advances 7->0 with wrap.
//  Output drive: all outputs are registered (1 clock after the counters).
//    div < BLANK_CYC: STRING=0, COLUMN=off.
//    Otherwise: STRING=1<<row, COLUMN=active[row] (inverted if COL_ACTIVE_LOW).
//  blank_i=1: STRING=0 and COLUMN=off in the next cycle; counters unaffected.
//  Input handshake: on frame_vld & frame_rdy, shadow<=frame_i, shadow_full<=1,
//    frame_rdy<=0 (registered, so frame_rdy falls the next cycle).
//  Frame swap: at div==ROW_DIV-1 && row==7 && shadow_full, active<=shadow and
//    shadow_full<=0. frame_rdy returns to 1 the following cycle.
//    If the shadow is empty at the boundary, active is held (the last frame repeats).
//  frame_sync: pulses at every 7->0 wrap, with or without a swap.
//  Simultaneous events: accept and swap cannot coincide, because frame_rdy=0
//    whenever shadow_full=1. frame_vld while frame_rdy=0 is ignored; the
//    producer holds its data.
//  Width rule: div width is $clog2(ROW_DIV); row width is 3.
// STRUCTURE
//  Package lr4_pkg: ROWS=8, COLS=8, FRAME_W=64, col_off(COL_ACTIVE_LOW) constant.
//  Sub-module row_timer: div counter plus row counter. Outputs row, blank_win
//    (div<BLANK_CYC), row_end (div==ROW_DIV-1), frame_end (row_end & row==7).
//  Top level holds the shadow/active registers, the handshake and the output registers.
// TESTING  (ROW_RATE=CLK_REF/16 -> ROW_DIV=16, BLANK_CYC=2, COL_ACTIVE_LOW=1)
//  1 Reset 3 clocks, then check outputs -> STRING=00, COLUMN=FF, frame_rdy=1,
//    frame_sync=0. Blank for 2 clocks, then STRING=01 and COLUMN=FF (active=0).
//  2 Load frame 64'h8040201008040201 in row 7 dwell -> after swap each row r shows
//    STRING=1<<r, COLUMN=~(1<<r), 14 clocks lit of every 16; frame_sync period = 128 clocks.
//  3 Hold frame_vld with a second frame while shadow full -> frame_rdy=0, second frame
//    not taken until the swap; display changes only at the row-7->0 boundary.
//  4 Assert blank_i for 40 clocks mid-frame -> STRING=00/COLUMN=FF within 1 clock;
//    after release the row index equals the undisturbed schedule (no slip).
//  5 Load 64'hFFFF..FF, then assert rst during row 4 with a frame pending in shadow ->
//    next cycle all outputs at reset values, pending frame lost, active=0, scan restarts at row 0.
//  6 No new frame for 3 frames -> frame_sync pulses every 128 clocks and active
//    contents repeat unchanged.

Source files
------------

// File: rtl/led_matrix_scan_pkg.sv
// Shared constants and column-polarity helpers for the 8x8 LED matrix scanner.
package lr4_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FRAME_W = ROWS * COLS;

  typedef logic [ROWS-1:0]    row_sel_t;
  typedef logic [COLS-1:0]    col_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Column pattern that leaves every pixel dark for the given polarity.
  function automatic col_t col_off(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

  // Convert a "1 = lit" pixel row into the pin levels for the given polarity.
  function automatic col_t col_drive(input col_t lit, input bit active_low);
    return lit ^ col_off(active_low);
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame transfer channel from the glyph stage into the matrix scanner.
interface led_matrix_scan_if;

  logic [lr4_pkg::FRAME_W-1:0] frame_i;
  logic                        frame_vld;
  logic                        frame_rdy;

  modport master (output frame_i, output frame_vld, input  frame_rdy);
  modport slave  (input  frame_i, input  frame_vld, output frame_rdy);

endinterface

// File: rtl/led_matrix_scan_row_timer.sv
// Row dwell timer: divides the system clock into row slots and walks rows 0..7.
module row_timer #(
  parameter int ROW_DIV   = 6000,
  parameter int BLANK_CYC = 48
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] row,
  output logic       blank_win,
  output logic       row_end,
  output logic       frame_end
);

  localparam int DIV_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ROW_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] div;

  // Dwell counter wraps at the end of each row; row index wraps 7 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      row <= '0;
    end else if (row_end) begin
      div <= '0;
      row <= row + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign blank_win = (div < BLANK_END);
  assign row_end   = (div == DIV_LAST);
  assign frame_end = row_end && (row == 3'd7);

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered row-multiplexed driver for the 8x8 LED matrix.
module led_matrix_scan
  import lr4_pkg::*;
#(
  parameter int CLK_REF        = 48_000_000,
  parameter int ROW_RATE       = 8_000,
  parameter int BLANK_CYC      = 48,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  led_matrix_scan_if.slave  frm,
  input  logic              blank_i,
  output logic [ROWS-1:0]   STRING,
  output logic [COLS-1:0]   COLUMN,
  output logic              frame_sync
);

  localparam int ROW_DIV = CLK_REF / ROW_RATE;

  logic [2:0] row_p0;
  logic       blank_win_p0;
  logic       row_end_p0;
  logic       frame_end_p0;

  row_timer #(
    .ROW_DIV   (ROW_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_row_timer (
    .clk       (clk),
    .rst       (rst),
    .row       (row_p0),
    .blank_win (blank_win_p0),
    .row_end   (row_end_p0),
    .frame_end (frame_end_p0)
  );

  frame_t   shadow_p0;
  frame_t   active_p0;
  logic     shadow_full_p0;
  logic     rdy_p0;
  logic     vld_p0;
  col_t     row_pix_p0;
  row_sel_t string_p1;
  col_t     column_p1;
  logic     sync_p1;

  // rdy is low exactly while the shadow holds a frame, so accept and swap never coincide.
  assign vld_p0         = frm.frame_vld && rdy_p0;
  assign frm.frame_rdy  = rdy_p0;
  assign row_pix_p0     = active_p0[{row_p0, 3'b000} +: COLS];

  // Shadow data capture; content is only meaningful while shadow_full_p0 is set.
  always_ff @(posedge clk) begin
    if (vld_p0) shadow_p0 <= frm.frame_i;
  end

  // Handshake and frame swap: the displayed frame changes only at the row 7 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_full_p0 <= 1'b0;
      rdy_p0         <= 1'b1;
      active_p0      <= '0;
    end else if (vld_p0) begin
      shadow_full_p0 <= 1'b1;
      rdy_p0         <= 1'b0;
    end else if (frame_end_p0 && shadow_full_p0) begin
      active_p0      <= shadow_p0;
      shadow_full_p0 <= 1'b0;
      rdy_p0         <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: registered pin drive, one clock behind the timer ----
  // Pins go dark during the blanking window or when forced dark; timing never pauses.
  always_ff @(posedge clk) begin
    if (rst) begin
      string_p1 <= '0;
      column_p1 <= col_off(COL_ACTIVE_LOW);
      sync_p1   <= 1'b0;
    end else begin
      sync_p1 <= frame_end_p0;
      if (blank_win_p0 || blank_i) begin
        string_p1 <= '0;
        column_p1 <= col_off(COL_ACTIVE_LOW);
      end else begin
        string_p1 <= row_sel_t'(1) << row_p0;
        column_p1 <= col_drive(row_pix_p0, COL_ACTIVE_LOW);
      end
    end
  end

  assign STRING     = string_p1;
  assign COLUMN     = column_p1;
  assign frame_sync = sync_p1;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan with a 16-clock row dwell and 2-clock blanking.
module tb_led_matrix_scan;

  localparam int CLK_REF  = 48_000_000;
  localparam int ROW_RATE = CLK_REF / 16;
  localparam int BLANK    = 2;
  localparam int DWELL    = 16;
  localparam int FRAME_T  = 8 * DWELL;

  localparam logic [63:0] F1 = 64'h8040201008040201;
  localparam logic [63:0] F2 = 64'h00FF00FF00FF00FF;
  localparam logic [63:0] F3 = 64'h0102040810204080;
  localparam logic [63:0] FA = 64'hFFFFFFFFFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank_i;
  logic [7:0] STRING;
  logic [7:0] COLUMN;
  logic       frame_sync;

  led_matrix_scan_if bus();

  led_matrix_scan #(
    .CLK_REF        (CLK_REF),
    .ROW_RATE       (ROW_RATE),
    .BLANK_CYC      (BLANK),
    .COL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frm        (bus),
    .blank_i    (blank_i),
    .STRING     (STRING),
    .COLUMN     (COLUMN),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: scan position is simply clocks since reset modulo one frame.
  int          k;
  int          pos, r, d;
  bit          mok = 1'b0;
  bit          m_full, m_rdy, swap, accept;
  logic [63:0] m_act, m_sh;
  logic [7:0]  lit;
  logic [7:0]  e_str, e_col;
  logic        e_sync, e_rdy;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_act = '0; m_full = 1'b0; m_rdy = 1'b1;
      e_str = 8'h00; e_col = 8'hFF; e_sync = 1'b0; mok = 1'b1;
    end else begin
      pos = k % FRAME_T;
      r   = pos / DWELL;
      d   = pos % DWELL;
      lit = m_act[r*8 +: 8];
      if (blank_i || d < BLANK) begin
        e_str = 8'h00; e_col = 8'hFF;
      end else begin
        e_str = 8'(1 << r); e_col = ~lit;
      end
      e_sync = (pos == FRAME_T - 1);
      swap   = (pos == FRAME_T - 1) && m_full;
      accept = bus.frame_vld && m_rdy;
      if (accept) begin m_sh = bus.frame_i; m_full = 1'b1; m_rdy = 1'b0; end
      if (swap)   begin m_act = m_sh; m_full = 1'b0; m_rdy = 1'b1; end
      k++;
    end
    e_rdy = m_rdy;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mok) begin
      cmp("STRING_model",     32'(STRING),        32'(e_str));
      cmp("COLUMN_model",     32'(COLUMN),        32'(e_col));
      cmp("frame_sync_model", 32'(frame_sync),    32'(e_sync));
      cmp("frame_rdy_model",  32'(bus.frame_rdy), 32'(e_rdy));
    end
  end

  int e;
  int cnt;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    e += n;
  endtask

  initial begin
    rst = 1'b1; blank_i = 1'b0; bus.frame_vld = 1'b0; bus.frame_i = '0; e = 0;
    repeat (3) @(negedge clk);
    cmp("rst_STRING", 32'(STRING), 32'h00);
    cmp("rst_COLUMN", 32'(COLUMN), 32'hFF);
    cmp("rst_rdy",    32'(bus.frame_rdy), 32'h1);
    cmp("rst_sync",   32'(frame_sync), 32'h0);
    rst = 1'b0;
    step(2);   cmp("blank_first", 32'(STRING), 32'h00);
    step(1);   cmp("row0_STRING", 32'(STRING), 32'h01);
               cmp("row0_COLUMN", 32'(COLUMN), 32'hFF);

    // first frame loaded during the row 7 dwell
    step(109); bus.frame_vld = 1'b1; bus.frame_i = F1;
    step(1);   bus.frame_vld = 1'b0; cmp("rdy_after_load", 32'(bus.frame_rdy), 32'h0);
    step(69);  cmp("f1_row3_STRING", 32'(STRING), 32'h08);
               cmp("f1_row3_COLUMN", 32'(COLUMN), 32'hF7);

    // second frame waits in the shadow, third is held off until the swap
    step(18);  bus.frame_vld = 1'b1; bus.frame_i = F2;
    step(1);   bus.frame_i = F3; cmp("rdy_shadow_full", 32'(bus.frame_rdy), 32'h0);
    step(49);  cmp("f1_row7_STRING", 32'(STRING), 32'h80);
               cmp("f1_row7_COLUMN", 32'(COLUMN), 32'h7F);
    step(6);   cmp("rdy_after_swap", 32'(bus.frame_rdy), 32'h1);
               cmp("sync_at_wrap",   32'(frame_sync), 32'h1);
    step(1);   bus.frame_vld = 1'b0; cmp("rdy_third_taken", 32'(bus.frame_rdy), 32'h0);
    step(3);   cmp("f2_row0_STRING", 32'(STRING), 32'h01);
               cmp("f2_row0_COLUMN", 32'(COLUMN), 32'h00);

    // forced blanking mid-frame, then check the schedule did not slip
    step(40);  blank_i = 1'b1;
    step(1);   cmp("blank_STRING", 32'(STRING), 32'h00);
               cmp("blank_COLUMN", 32'(COLUMN), 32'hFF);
    step(39);  blank_i = 1'b0;
    step(1);   cmp("unblank_row5_STRING", 32'(STRING), 32'h20);
               cmp("unblank_row5_COLUMN", 32'(COLUMN), 32'hFF);
    step(16);  cmp("unblank_row6_STRING", 32'(STRING), 32'h40);
               cmp("unblank_row6_COLUMN", 32'(COLUMN), 32'h00);

    // reset in row 4 with an all-on frame pending
    step(27);  bus.frame_vld = 1'b1; bus.frame_i = FA;
    step(1);   bus.frame_vld = 1'b0;
    step(65);  rst = 1'b1;
    step(1);   cmp("midrst_STRING", 32'(STRING), 32'h00);
               cmp("midrst_COLUMN", 32'(COLUMN), 32'hFF);
               cmp("midrst_rdy",    32'(bus.frame_rdy), 32'h1);
               cmp("midrst_sync",   32'(frame_sync), 32'h0);
    rst = 1'b0; e = 0;
    step(3);   cmp("restart_STRING", 32'(STRING), 32'h01);
               cmp("restart_COLUMN", 32'(COLUMN), 32'hFF);
    step(145); cmp("lost_row1_STRING", 32'(STRING), 32'h02);
               cmp("lost_row1_COLUMN", 32'(COLUMN), 32'hFF);

    // one frame, then three frames with no new data
    bus.frame_vld = 1'b1; bus.frame_i = F1;
    step(1);   bus.frame_vld = 1'b0;
    cnt = 0;
    while (frame_sync !== 1'b1 && cnt < 300) begin step(1); cnt++; end
    cmp("sync_first_seen", 32'(frame_sync), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      do begin step(1); cnt++; end while (frame_sync !== 1'b1 && cnt < 300);
      cmp("sync_period", 32'(cnt), 32'(FRAME_T));
    end
    step(116); cmp("repeat_row7_STRING", 32'(STRING), 32'h80);
               cmp("repeat_row7_COLUMN", 32'(COLUMN), 32'h7F);
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
